// File: rtl/user_id_enroll.sv
// Enrollment controller for the user ID file: scans all entries for a duplicate and the
// first free slot, writes a new ID there, and reports the outcome with a one-cycle pulse.
module user_id_enroll #(
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ID_WIDTH-1:0]   i_id_input,
    input  logic                  i_enroll_req,
    input  logic [ID_WIDTH-1:0]   i_q_uid,
    output logic [ADDR_WIDTH-1:0] o_address_user,
    output logic [ID_WIDTH-1:0]   o_data_uid,
    output logic                  o_wren_uid,
    output logic                  o_busy,
    output logic                  o_enroll_ok,
    output logic                  o_enroll_dup,
    output logic                  o_enroll_full,
    output logic                  o_enroll_inv
);

    typedef enum logic [2:0] {StIdle, StScan, StLast, StWrite, StResp} state_t;
    typedef enum logic [1:0] {ResOk, ResDup, ResFull, ResInv} result_t;

    state_t                r_state, w_state_nxt;
    result_t               r_result, w_result_nxt;
    logic [ADDR_WIDTH:0]   r_cnt, w_cnt_nxt;
    logic                  r_dup, w_dup_nxt;
    logic                  r_free, w_free_nxt;
    logic [ADDR_WIDTH-1:0] r_free_idx, w_free_idx_nxt;
    logic [ID_WIDTH-1:0]   r_id, w_id_nxt;

    logic                  w_hit;
    logic                  w_empty;
    logic [ADDR_WIDTH:0]   w_cnt_inc;
    logic [ADDR_WIDTH-1:0] w_prev_idx;

    assign w_hit      = (i_q_uid == r_id);
    assign w_empty    = (i_q_uid == '0);
    assign w_cnt_inc  = r_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
    // Read data arriving now belongs to the address driven one cycle earlier
    assign w_prev_idx = r_cnt[ADDR_WIDTH-1:0] - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt    = r_state;
        w_result_nxt   = r_result;
        w_cnt_nxt      = r_cnt;
        w_dup_nxt      = r_dup;
        w_free_nxt     = r_free;
        w_free_idx_nxt = r_free_idx;
        w_id_nxt       = r_id;

        case (r_state)
            StIdle: begin
                if (i_enroll_req) begin
                    w_id_nxt       = i_id_input;
                    w_cnt_nxt      = '0;
                    w_dup_nxt      = 1'b0;
                    w_free_nxt     = 1'b0;
                    w_free_idx_nxt = '0;
                    if (i_id_input == '0) begin
                        w_result_nxt = ResInv;
                        w_state_nxt  = StResp;
                    end else begin
                        w_state_nxt  = StScan;
                    end
                end
            end
            StScan: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_cnt != '0) begin
                    if (w_hit) begin
                        w_dup_nxt = 1'b1;
                    end
                    if (w_empty && !r_free) begin
                        w_free_nxt     = 1'b1;
                        w_free_idx_nxt = w_prev_idx;
                    end
                end
                if (w_cnt_inc[ADDR_WIDTH]) begin
                    w_state_nxt = StLast;
                end
            end
            StLast: begin
                if (w_empty && !r_free) begin
                    w_free_nxt     = 1'b1;
                    w_free_idx_nxt = {ADDR_WIDTH{1'b1}};
                end
                // A duplicate wins even when the table is full
                if (r_dup || w_hit) begin
                    w_dup_nxt    = 1'b1;
                    w_result_nxt = ResDup;
                    w_state_nxt  = StResp;
                end else if (!(r_free || w_empty)) begin
                    w_result_nxt = ResFull;
                    w_state_nxt  = StResp;
                end else begin
                    w_state_nxt  = StWrite;
                end
            end
            StWrite: begin
                w_result_nxt = ResOk;
                w_state_nxt  = StResp;
            end
            StResp: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_result   <= ResOk;
            r_cnt      <= '0;
            r_dup      <= 1'b0;
            r_free     <= 1'b0;
            r_free_idx <= '0;
            r_id       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_result   <= w_result_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dup      <= w_dup_nxt;
            r_free     <= w_free_nxt;
            r_free_idx <= w_free_idx_nxt;
            r_id       <= w_id_nxt;
        end
    end

    always_comb begin
        o_address_user = '0;
        if (r_state == StScan) begin
            o_address_user = r_cnt[ADDR_WIDTH-1:0];
        end else if (r_state == StWrite) begin
            o_address_user = r_free_idx;
        end
    end

    assign o_data_uid    = r_id;
    assign o_wren_uid    = (r_state == StWrite);
    assign o_busy        = (r_state != StIdle);
    assign o_enroll_ok   = (r_state == StResp) && (r_result == ResOk);
    assign o_enroll_dup  = (r_state == StResp) && (r_result == ResDup);
    assign o_enroll_full = (r_state == StResp) && (r_result == ResFull);
    assign o_enroll_inv  = (r_state == StResp) && (r_result == ResInv);

endmodule

// File: tb/tb_user_id_enroll.sv
// Directed bench for user_id_enroll with a 1-cycle-latency table model and
// cycle-exact checks of the scan, write and status timing.
module tb_user_id_enroll;

    localparam int K_OK   = 0;
    localparam int K_DUP  = 1;
    localparam int K_FULL = 2;
    localparam int K_INV  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [15:0] id;
    logic [15:0] q_uid;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        wren, busy, ok, dup, full, inv;

    int total  = 0;
    int bad    = 0;
    int wr_cnt = 0;
    int st_cnt = 0;

    logic [15:0] mem [8];
    logic [15:0] tbl [8];
    logic        ld = 1'b0;

    user_id_enroll #(.ID_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_id_input     (id),
        .i_enroll_req   (req),
        .i_q_uid        (q_uid),
        .o_address_user (addr),
        .o_data_uid     (data),
        .o_wren_uid     (wren),
        .o_busy         (busy),
        .o_enroll_ok    (ok),
        .o_enroll_dup   (dup),
        .o_enroll_full  (full),
        .o_enroll_inv   (inv)
    );

    always #5 clk = ~clk;

    // Table model: read latency 1, write commits at the edge ending the wren cycle
    always @(posedge clk) begin
        q_uid <= mem[addr];
        if (ld) begin
            for (int i = 0; i < 8; i++) mem[i] <= tbl[i];
        end else if (wren) begin
            mem[addr] <= data;
        end
        if (wren) wr_cnt <= wr_cnt + 1;
        if (ok | dup | full | inv) st_cnt <= st_cnt + 1;
    end

    function automatic logic [3:0] st();
        return {ok, dup, full, inv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load();
        ld = 1'b1;
        tick();
        ld = 1'b0;
    endtask

    task automatic enroll(input logic [15:0] v, input int kind, input logic [2:0] waddr);
        int w0;
        logic [3:0] exp_st;
        w0 = wr_cnt;
        exp_st = (kind == K_DUP) ? 4'b0100 : 4'b0010;
        id  = v;
        req = 1'b1;
        tick();
        req = 1'b0;
        if (kind == K_INV) begin
            chk("inv_pulse", {busy, wren, st()}, 6'b100001);
            chk("inv_addr", addr, 3'd0);
            tick();
            chk("inv_idle", {busy, st()}, 5'b00000);
        end else begin
            for (int i = 0; i < 8; i++) begin
                chk("scan_addr", addr, i);
                chk("scan_ctl", {busy, wren, st()}, 6'b100000);
                tick();
            end
            chk("last_ctl", {busy, wren, st()}, 6'b100000);
            tick();
            if (kind == K_OK) begin
                chk("wr_en", {busy, wren, st()}, 6'b110000);
                chk("wr_addr", addr, waddr);
                chk("wr_data", data, v);
                tick();
                chk("ok_pulse", {busy, wren, st()}, 6'b101000);
                tick();
                chk("ok_idle", {busy, st()}, 5'b00000);
            end else begin
                chk("resp_pulse", {busy, wren, st()}, {2'b10, exp_st});
                tick();
                chk("resp_idle", {busy, st()}, 5'b00000);
            end
        end
        chk("write_count", wr_cnt - w0, (kind == K_OK) ? 1 : 0);
    endtask

    initial begin
        int w0, s0;
        rst = 1'b1;
        req = 1'b0;
        id  = '0;
        for (int i = 0; i < 8; i++) tbl[i] = '0;
        @(negedge clk);
        do_load();
        tick();
        chk("reset_outputs", {addr, data, wren, busy, st()}, 25'd0);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", {addr, wren, busy, st()}, 9'd0);

        // Empty table: first slot is 0
        enroll(16'hCCC3, K_OK, 3'd0);
        chk("mem0_written", mem[0], 16'hCCC3);
        chk("mem1_clear", mem[1], 16'h0000);

        // First free slot is 3, not 6
        tbl = '{16'h1111, 16'h2222, 16'h3333, 16'h0000, 16'h4444, 16'h5555, 16'h0000, 16'h7777};
        do_load();
        enroll(16'hABCD, K_OK, 3'd3);
        chk("mem3_written", mem[3], 16'hABCD);
        chk("mem6_free", mem[6], 16'h0000);

        // Duplicate beats an available free slot
        tbl = '{16'h0101, 16'h0202, 16'h0000, 16'h0404, 16'h0505, 16'hCCC3, 16'h0707, 16'h0808};
        do_load();
        enroll(16'hCCC3, K_DUP, 3'd0);
        chk("mem2_untouched", mem[2], 16'h0000);

        // Full table, then a duplicate in entry 7 of the full table
        tbl = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0F00};
        do_load();
        enroll(16'h0F0F, K_FULL, 3'd0);
        enroll(16'h0F00, K_DUP, 3'd0);

        // Only entry 7 free
        tbl = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0000};
        do_load();
        enroll(16'h5A5A, K_OK, 3'd7);
        chk("mem7_written", mem[7], 16'h5A5A);

        // Invalid ID, then request held through busy
        enroll(16'h0000, K_INV, 3'd0);
        w0 = wr_cnt;
        id  = 16'h0000;
        req = 1'b1;
        tick();
        chk("held_inv1", {busy, st()}, 5'b10001);
        tick();
        chk("held_ignored", {busy, st()}, 5'b00000);
        tick();
        chk("held_inv2", {busy, st()}, 5'b10001);
        req = 1'b0;
        tick();
        chk("held_idle", {busy, st()}, 5'b00000);
        chk("held_no_write", wr_cnt - w0, 0);

        // Reset in the cycle after E4 of an OK-path enrollment
        tbl = '{16'h1111, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        do_load();
        w0 = wr_cnt;
        s0 = st_cnt;
        id  = 16'h1234;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (4) tick();
        chk("pre_reset_addr", addr, 3'd4);
        rst = 1'b1;
        tick();
        chk("mid_reset_outputs", {addr, data, wren, busy, st()}, 25'd0);
        rst = 1'b0;
        repeat (12) tick();
        chk("rst_no_write", wr_cnt - w0, 0);
        chk("rst_no_status", st_cnt - s0, 0);
        chk("rst_mem0", mem[0], 16'h1111);
        chk("rst_mem1", mem[1], 16'h0000);
        chk("rst_idle", {busy, wren}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/user_id_enroll.md
# user_id_enroll

Enrollment (write-side) controller for the user ID file. It accepts a new 16-bit user ID and scans the 8-entry table for a duplicate and the first free slot. If the ID is new and a slot is free, it writes the ID into that slot. It drives the same address/data bus that the login controller reads through, and reports one of four outcomes with a single-cycle status pulse.

## Interface
- ID_WIDTH, 16, width of a user ID word
- ADDR_WIDTH, 3, table address width; table depth = 2**ADDR_WIDTH (8)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- id_input  input  ID_WIDTH  ID to enroll; sampled only when a request is accepted
- enroll_req  input  1  request strobe; honoured only in IDLE
- q_uid  input  ID_WIDTH  read data from the user ID file
- address_user  output  ADDR_WIDTH  table address for reads and the write
- data_uid  output  ID_WIDTH  write data (the latched ID)
- wren_uid  output  1  write enable, one cycle wide
- busy  output  1  high from acceptance until the status pulse ends
- enroll_ok  output  1  pulse: ID written
- enroll_dup  output  1  pulse: ID already present, no write
- enroll_full  output  1  pulse: no free slot, no write
- enroll_inv  output  1  pulse: ID was 0 (reserved empty marker), no write

## Operation
- A table entry equal to 0 is free. ID 0 can never be enrolled.
- Memory read latency is 1: an address driven in cycle k returns its data on q_uid in cycle k+1.
- FSM states: IDLE, SCAN, LAST, WRITE, RESP.
- IDLE
  - enroll_req=1 latches id_input into id_reg.
  - If id_input==0: go to RESP with result INV.
  - Otherwise: go to SCAN with addr counter = 0.
- SCAN
  - address_user = counter; the counter increments each cycle.
  - Each cycle compares q_uid (entry counter-1) against id_reg. The compare is skipped on the first SCAN cycle.
  - A match sets dup_flag.
  - The first q_uid==0 sets free_flag and captures free_idx. Later free entries do not overwrite free_idx.
  - After address 7 is driven, go to LAST.
- LAST
  - Compares entry 7.
  - Result priority: dup > full > ok. A duplicate sitting in a full table reports dup.
  - Result ok goes to WRITE; dup or full goes to RESP.
- WRITE
  - address_user = free_idx, data_uid = id_reg, wren_uid = 1 for exactly one cycle.
  - Then go to RESP with result OK.
- RESP
  - Exactly one status output is high for one cycle. busy stays high during this cycle.
  - Then go to IDLE.
- In IDLE: address_user = 0, wren_uid = 0, busy = 0. data_uid holds id_reg at all times.
- enroll_req while busy is ignored and is not queued.
- Arithmetic: the counter is ADDR_WIDTH+1 bits so that the end-of-scan condition is unambiguous. address_user takes its low ADDR_WIDTH bits. There is no wrap-around within a scan.

## Timing
- Reset values: address_user=0, data_uid=0, wren_uid=0, busy=0, and all status pulses 0. FSM=IDLE; counter, flags, free_idx and id_reg cleared.
- Reset has priority over every state. Reset asserted mid-scan or in WRITE returns to IDLE on the next edge with wren_uid low. No partial write and no status pulse occur.
- Edge numbering: request sampled at edge E0.
  - address_user = i during the cycle after E(i), for i = 0..7.
  - Entry i is compared at edge E(i+2), so entry 7 is compared at E9.
- OK path: wren_uid high during the cycle after E9; the write commits at E10. enroll_ok is high in the cycle after E10; busy falls at E11. Total: 11 cycles from acceptance to idle.
- DUP/FULL path: status pulse in the cycle after E9; busy falls at E10.
- INV path: enroll_inv in the cycle after E0; busy falls at E1.
- busy rises in the cycle after E0.
- A new request is accepted at the first edge where the FSM is in IDLE, i.e. back-to-back requests are allowed once busy is low.

## Test plan
- Empty table (all 0), id_input=16'hCCC3 → reads of addr 0..7, then wren_uid=1 with address_user=0 and data_uid=16'hCCC3. enroll_ok pulses in the cycle after E10 and a re-read of entry 0 returns 16'hCCC3.
- Entries 0–2 = 16'h1111/16'h2222/16'h3333, entries 3 and 6 = 0, id=16'hABCD → write to address 3 (first free, not 6), then enroll_ok.
- Entry 5 = 16'hCCC3 and entry 2 = 0, id=16'hCCC3 → no wren_uid. enroll_dup pulses in the cycle after E9 even though a free slot exists.
- All entries nonzero and distinct from the ID 16'h0F0F → no wren_uid, enroll_full pulse in the cycle after E9. A second case with the ID present in the full table gives enroll_dup.
- id_input=16'h0000 with enroll_req → enroll_inv in the cycle after E0, no reads and no write. enroll_req held high through busy is accepted again only after busy falls.
- rst asserted in the cycle after E4 of an OK-path enrollment → all outputs at reset values on the next edge. The table is unchanged and none of the four status outputs pulses.
